// File: rtl/prog_mem.sv
// Instruction memory with a combinational fetch port and a byte-stream program loader.
// The loader packs bytes little-endian into words and holds the core in reset while it writes.
module prog_mem #(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc,
  output logic [31:0] o_inst,
  input  logic        i_ld_start,
  input  logic [15:0] i_ld_len,
  input  logic        i_ld_abort,
  input  logic        i_ld_valid,
  input  logic [7:0]  i_ld_data,
  output logic        o_ld_ready,
  output logic        o_cpu_rst_n,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_word_addr;
  logic [AW-1:0] r_last_addr;
  logic [1:0]    r_byte_cnt;
  logic [31:0]   r_asm;
  logic          r_done;
  logic          r_err;
  logic          r_cpu_rst_n;
  logic [31:0]   r_mem [DEPTH];

  logic          w_len_bad;
  logic          w_accept;
  logic          w_word_done;
  logic [31:0]   w_asm_next;
  logic          w_in_range;
  logic [1:0]    w_unused_pc_bits;

  // 17-bit compare so a length equal to DEPTH is accepted even when DEPTH == 2**16 would not fit.
  assign w_len_bad   = (i_ld_len == 16'd0) || ({1'b0, i_ld_len} > 17'(DEPTH));
  assign w_accept    = (r_state == S_LOAD) && !i_ld_abort && i_ld_valid;
  assign w_word_done = w_accept && (r_byte_cnt == 2'd3);

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[{r_byte_cnt, 3'b000} +: 8] = i_ld_data;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_ld_start && !w_len_bad) w_next = S_LOAD;
      S_LOAD: begin
        if (i_ld_abort)                                     w_next = S_IDLE;
        else if (w_word_done && r_word_addr == r_last_addr) w_next = S_HOLD;
      end
      S_HOLD:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_word_addr <= '0;
      r_last_addr <= '0;
      r_byte_cnt  <= '0;
      r_asm       <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cpu_rst_n <= (w_next == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_ld_start) begin
            r_done <= 1'b0;
            if (w_len_bad) begin
              r_err <= 1'b1;
            end else begin
              r_err       <= 1'b0;
              r_last_addr <= AW'(i_ld_len - 16'd1);
              r_word_addr <= '0;
              r_byte_cnt  <= '0;
            end
          end
        end
        S_LOAD: begin
          if (i_ld_abort) begin
            r_err <= 1'b1;
          end else if (w_accept) begin
            r_asm      <= w_asm_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) r_word_addr <= r_word_addr + AW'(1);
          end
        end
        S_HOLD:  r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; a reset mid-load must leave already written words intact.
  always_ff @(posedge i_clk) begin
    if (w_word_done) r_mem[r_word_addr] <= w_asm_next;
  end

  assign w_in_range       = (i_pc[31:AW+2] == '0);
  assign w_unused_pc_bits = i_pc[1:0];
  assign o_inst = (r_state == S_IDLE && w_in_range) ? r_mem[i_pc[AW+1:2]] : NOP;

  assign o_ld_ready  = (r_state == S_LOAD);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_cpu_rst_n = r_cpu_rst_n;

endmodule

// File: doc/prog_mem.md
# prog_mem

Instruction memory and program loader serving the CPU fetch port. It answers `i_pc` with a combinational instruction word in the same cycle, as the single-cycle core requires. It also accepts a byte-stream program image over a valid/ready handshake, assembles it into little-endian words, and holds the core in reset while the image is written.

## Interface

Parameters:
- `DEPTH`, 1024: memory size in 32-bit words, power of two, at most 16384.
- `NOP`, 32'h00000013: word returned for out-of-range and in-load fetches (`addi x0,x0,0`).

Ports:
- `i_clk` input, 1: clock.
- `i_rst_n` input, 1: asynchronous, active-low reset.
- `i_pc` input, 32: fetch byte address from the core.
- `o_inst` output, 32: instruction word, combinational from `i_pc`.
- `i_ld_start` input, 1: single-cycle pulse that starts a load.
- `i_ld_len` input, 16: image length in words; sampled with `i_ld_start`.
- `i_ld_abort` input, 1: cancels an in-progress load.
- `i_ld_valid` input, 1: byte-stream valid.
- `i_ld_data` input, 8: stream byte.
- `o_ld_ready` output, 1: byte accepted when `i_ld_valid && o_ld_ready`.
- `o_cpu_rst_n` output, 1: registered; drives the core `i_rst_n`.
- `o_busy` output, 1: high in LOAD or HOLD.
- `o_done` output, 1: sticky; last load completed.
- `o_err` output, 1: sticky; last start was rejected or aborted.

## Operation

- Storage: `DEPTH` x 32 array. Memory contents are not reset.
- Fetch, combinational:
  - Word index = `i_pc[$clog2(DEPTH)+1:2]`; `i_pc[1:0]` is ignored.
  - `o_inst` = `NOP` if `i_pc >= 4*DEPTH` or the state is not IDLE; otherwise it is the stored word.
- States: IDLE, LOAD, HOLD.
- IDLE:
  - `o_ld_ready` = 0.
  - On `i_ld_start`: if `i_ld_len == 0` or `i_ld_len > DEPTH`, set `o_err`, clear `o_done`, and stay in IDLE.
  - Otherwise latch the length, clear the word address, byte count, `o_err` and `o_done`, then go to LOAD.
- LOAD:
  - `o_ld_ready` = 1.
  - Each accepted byte is placed into byte lane `byte_cnt` of the assembly register; the first byte goes to [7:0].
  - On the 4th byte, the assembled word, including that byte, is written to `mem[word_addr]`. Then `word_addr` increments and `byte_cnt` wraps to 0.
  - If that write targets `word_addr == len-1`, go to HOLD.
  - `i_ld_start` in LOAD is ignored.
- Abort in LOAD:
  - `i_ld_abort` takes priority over a same-cycle byte; that byte is not accepted.
  - Go to IDLE and set `o_err`.
  - Words already written stay written; a partial word is discarded.
- HOLD: lasts exactly 1 cycle, then IDLE, setting `o_done`.
- `o_cpu_rst_n` is registered as `next_state == IDLE`.
- Widths:
  - `word_addr` is `$clog2(DEPTH)` bits.
  - The length compare is done at 16 bits plus 1 bit, so `DEPTH == i_ld_len` is accepted.
  - `byte_cnt` is 2 bits and wraps naturally.

## Timing

- Reset values:
  - State IDLE; `byte_cnt`, `word_addr` and the assembly register are 0.
  - `o_cpu_rst_n` = 0, `o_ld_ready` = 0, `o_busy` = 0, `o_done` = 0, `o_err` = 0.
- `o_cpu_rst_n` rises at the first `i_clk` edge after `i_rst_n` deasserts.
- Start: at the edge sampling `i_ld_start`, `o_cpu_rst_n` falls and `o_busy`/`o_ld_ready` rise.
- Throughput: 1 byte per cycle; `i_ld_valid` gaps of any length are allowed.
- Write latency: the word is visible on `o_inst` after the edge accepting its 4th byte, once the state returns to IDLE.
- Completion:
  - Edge accepting the final byte: state goes to HOLD, `o_ld_ready` = 0.
  - Next edge: state goes to IDLE, `o_cpu_rst_n` = 1, `o_done` = 1, `o_busy` = 0.
- Core-reset hold: `o_cpu_rst_n` is low for 4*len + 1 cycles minimum.
- Reset mid-load: returns immediately to IDLE with all reset values above. Memory retains the partially written words.
- Abort: IDLE at the next edge; `o_cpu_rst_n` = 1 at that same edge.

## Test plan

- Load `i_ld_len`=2 with bytes 13 05 10 00 93 05 20 00, valid held high:
  - `mem[0]` = 0x00100513, `mem[1]` = 0x00200593.
  - `o_cpu_rst_n` low for exactly 9 cycles, then `o_done` = 1.
  - `i_pc`=4 gives 0x00200593; `i_pc`=6 also gives 0x00200593.
- Same image with `i_ld_valid` toggled every other cycle: identical memory contents; completion takes 16 cycles after start plus 1 HOLD cycle.
- Rejected starts:
  - `i_ld_len`=0: `o_err` = 1, state stays IDLE, `o_cpu_rst_n` stays 1.
  - `i_ld_len`=DEPTH+1: `o_err` = 1, state stays IDLE, `o_cpu_rst_n` stays 1.
  - `i_ld_len`=DEPTH: accepted.
- Abort after 6 bytes of a 2-word load:
  - `mem[0]` written; `mem[1]` unchanged.
  - `o_err` = 1, `o_done` = 0, `o_cpu_rst_n` = 1 next cycle.
- Assert `i_rst_n` low mid-load:
  - `o_cpu_rst_n` = 0, `o_busy` = 0, `o_ld_ready` = 0 immediately.
  - A fresh load afterwards completes normally.
- Out-of-range and in-load fetch:
  - `i_pc` = 4*DEPTH in IDLE gives 0x00000013.
  - Any `i_pc` during LOAD gives 0x00000013.
